// File: rtl/riscv_package.sv
// Shared RV32I decode types for the ALU issue path: operation enum, major
// opcodes and the payload carried from issue into the ALU.
package riscv_package;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  // ALU_ADD must stay at zero so a cleared payload reads as a plain add.
  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB,
    ALU_XOR,
    ALU_OR,
    ALU_AND,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_BEQ,
    ALU_BNE,
    ALU_BLT,
    ALU_BGE,
    ALU_BLTU,
    ALU_BGEU
  } alu_operation_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    alu_operation_e  operation;
    logic [REGW-1:0] rd;
    logic            reg_write;
    logic            is_branch;
    logic            illegal;
  } issue_payload_t;

  // Shared funct3 map for OP and OP-IMM; alt selects SUB/SRA.
  function automatic alu_operation_e alu_funct3_op(input logic [2:0] f3, input logic alt);
    alu_operation_e op;
    unique case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_stage_alu_op_decode.sv
// Combinational RV32I field decode into an ALU issue payload.
module alu_op_decode
  import riscv_package::*;
(
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [REGW-1:0] rd_in,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output issue_payload_t  payload
);

  logic wr, ill, br, shift;

  always_comb begin
    payload           = '0;
    payload.operand_a = rs1_data;
    payload.operand_b = rs2_data;
    payload.operation = ALU_ADD;
    payload.rd        = rd_in;
    wr    = 1'b0;
    ill   = 1'b0;
    br    = 1'b0;
    shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    unique case (opcode)
      OPC_OP: begin
        wr  = 1'b1;
        ill = !((funct7 == 7'h00) ||
                (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
        payload.operation = alu_funct3_op(funct3, funct7[5]);
      end
      OPC_OP_IMM: begin
        wr  = 1'b1;
        payload.operand_b = imm;
        // funct7 only matters for shifts; ADDI never turns into SUB
        ill = shift && !((funct7 == 7'h00) || (funct7 == 7'h20 && funct3 == 3'b101));
        payload.operation = alu_funct3_op(funct3, (funct3 == 3'b101) && funct7[5]);
      end
      OPC_LOAD: begin
        wr = 1'b1;
        payload.operand_b = imm;
      end
      OPC_STORE: payload.operand_b = imm;
      OPC_LUI: begin
        wr = 1'b1;
        payload.operand_a = '0;
        payload.operand_b = imm;
      end
      OPC_AUIPC: begin
        wr = 1'b1;
        payload.operand_a = pc;
        payload.operand_b = imm;
      end
      OPC_BRANCH: begin
        br = 1'b1;
        unique case (funct3)
          3'b000:  payload.operation = ALU_BEQ;
          3'b001:  payload.operation = ALU_BNE;
          3'b100:  payload.operation = ALU_BLT;
          3'b101:  payload.operation = ALU_BGE;
          3'b110:  payload.operation = ALU_BLTU;
          3'b111:  payload.operation = ALU_BGEU;
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      payload.operation = ALU_ADD;
      wr = 1'b0;
      br = 1'b0;
    end
    payload.reg_write = wr && (rd_in != '0);
    payload.is_branch = br;
    payload.illegal   = ill;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode into a payload, then a 2-entry (main + skid) buffer
// so the ALU sees flopped operands and in_ready comes from a flop.
module alu_issue_stage
  import riscv_package::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [6:0]     opcode,
  input  logic [2:0]     funct3,
  input  logic [6:0]     funct7,
  input  logic [RW-1:0]  rd_in,
  input  logic [DW-1:0]  rs1_data,
  input  logic [DW-1:0]  rs2_data,
  input  logic [DW-1:0]  imm,
  input  logic [DW-1:0]  pc,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  operand_a,
  output logic [DW-1:0]  operand_b,
  output alu_operation_e operation,
  output logic [RW-1:0]  rd_out,
  output logic           reg_write,
  output logic           is_branch,
  output logic           illegal
);

  issue_payload_t dec, main_q, skid_q;
  logic           main_vld, skid_vld;

  alu_op_decode u_dec (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .rd_in    (rd_in),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .imm      (imm),
    .pc       (pc),
    .payload  (dec)
  );

  // A full skid implies a full main and in_ready=0, so no accept can race it.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (skid_vld) begin
      if (out_ready) begin
        main_q   <= skid_q;
        skid_vld <= 1'b0;
      end
    end else if (in_valid) begin
      if (!main_vld || out_ready) begin
        main_q   <= dec;
        main_vld <= 1'b1;
      end else begin
        skid_q   <= dec;
        skid_vld <= 1'b1;
      end
    end else if (out_ready) begin
      main_vld <= 1'b0;
    end
  end

  assign in_ready  = ~skid_vld;
  assign out_valid = main_vld;
  assign operand_a = main_q.operand_a;
  assign operand_b = main_q.operand_b;
  assign operation = main_q.operation;
  assign rd_out    = main_q.rd;
  assign reg_write = main_q.reg_write;
  assign is_branch = main_q.is_branch;
  assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus random traffic, compared
// each cycle against a queue-of-instructions reference model.
module tb_alu_issue_stage;
  import riscv_package::*;

  logic clk = 1'b0;
  logic reset, in_valid, flush, out_ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd_in;
  logic [31:0] rs1_data, rs2_data, imm, pc;
  logic in_ready, out_valid, reg_write, is_branch, illegal;
  logic [31:0] operand_a, operand_b;
  logic [4:0] rd_out;
  alu_operation_e operation;

  int checks = 0, errors = 0, consumed = 0, c0;

  typedef struct {
    logic [31:0] a, b;
    logic [4:0]  op, rd;
    logic        rw, br, ill;
  } exp_t;
  exp_t q[$];

  alu_issue_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd_in(rd_in),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .operand_a(operand_a), .operand_b(operand_b), .operation(operation),
    .rd_out(rd_out), .reg_write(reg_write), .is_branch(is_branch),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction semantics from the ISA tables, independent of RTL structure.
  function automatic exp_t model();
    exp_t e;
    alu_operation_e alu_tab[8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                   ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    alu_operation_e br_tab[8]  = '{ALU_BEQ, ALU_BNE, ALU_ADD, ALU_ADD,
                                   ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
    bit legal = 1'b1, writes = 1'b0;
    e.a = rs1_data; e.b = rs2_data; e.op = ALU_ADD; e.rd = rd_in; e.br = 1'b0;
    if (opcode == OPC_OP) begin
      writes = 1'b1;
      e.op = alu_tab[funct3];
      if (funct7 == 7'h20 && funct3 == 3'd0) e.op = ALU_SUB;
      if (funct7 == 7'h20 && funct3 == 3'd5) e.op = ALU_SRA;
      legal = (funct7 == 7'h00) || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
    end else if (opcode == OPC_OP_IMM) begin
      writes = 1'b1; e.b = imm;
      e.op = alu_tab[funct3];
      if (funct3 == 3'd5 && funct7 == 7'h20) e.op = ALU_SRA;
      if (funct3 == 3'd1 || funct3 == 3'd5)
        legal = (funct7 == 7'h00) || (funct3 == 3'd5 && funct7 == 7'h20);
    end else if (opcode == OPC_LOAD) begin
      writes = 1'b1; e.b = imm;
    end else if (opcode == OPC_STORE) begin
      e.b = imm;
    end else if (opcode == OPC_LUI) begin
      writes = 1'b1; e.a = 32'd0; e.b = imm;
    end else if (opcode == OPC_AUIPC) begin
      writes = 1'b1; e.a = pc; e.b = imm;
    end else if (opcode == OPC_BRANCH) begin
      e.br = 1'b1; e.op = br_tab[funct3];
      legal = (funct3 != 3'd2) && (funct3 != 3'd3);
    end else begin
      legal = 1'b0;
    end
    if (!legal) begin e.op = ALU_ADD; writes = 1'b0; e.br = 1'b0; end
    e.rw  = writes && (rd_in != 5'd0);
    e.ill = !legal;
    return e;
  endfunction

  // Check outputs against the model, advance the model, then cross the edge.
  task automatic tick();
    bit ev = (q.size() > 0);
    bit er = (q.size() < 2);
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("in_ready", 32'(in_ready), 32'(er));
    if (ev) begin
      chk("operand_a", operand_a, q[0].a);
      chk("operand_b", operand_b, q[0].b);
      chk("operation", 32'(operation), 32'(q[0].op));
      chk("rd_out", 32'(rd_out), 32'(q[0].rd));
      chk("reg_write", 32'(reg_write), 32'(q[0].rw));
      chk("is_branch", 32'(is_branch), 32'(q[0].br));
      chk("illegal", 32'(illegal), 32'(q[0].ill));
    end
    if (out_valid && out_ready) consumed++;
    if (reset) q.delete();
    else begin
      if (ev && out_ready) void'(q.pop_front());
      if (flush) q.delete();
      else if (in_valid && er) q.push_back(model());
    end
    @(posedge clk); #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] im, input logic [31:0] p);
    opcode = op; funct3 = f3; funct7 = f7; rd_in = rd;
    rs1_data = r1; rs2_data = r2; imm = im; pc = p; in_valid = 1'b1;
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_operand_a", operand_a, 32'd0);
    chk("rst_operand_b", operand_b, 32'd0);
    chk("rst_operation", 32'(operation), 32'(ALU_ADD));
    chk("rst_rd_out", 32'(rd_out), 32'd0);
    chk("rst_flags", {29'd0, reg_write, is_branch, illegal}, 32'd0);
  endtask

  initial begin
    logic [6:0] opc_list[8] = '{OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE,
                                OPC_LUI, OPC_AUIPC, OPC_BRANCH, 7'h7f};
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_instr(7'd0, 3'd0, 7'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_state();

    // SUB
    out_ready = 1'b1;
    set_instr(OPC_OP, 3'd0, 7'h20, 5'd5, 32'd10, 32'd3, 32'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_op", 32'(operation), 32'(ALU_SUB));
    chk("sub_a", operand_a, 32'd10);
    chk("sub_b", operand_b, 32'd3);
    chk("sub_rd", 32'(rd_out), 32'd5);
    chk("sub_rw", 32'(reg_write), 32'd1);
    tick();

    // SRAI, then the same fields with a bad funct7
    set_instr(OPC_OP_IMM, 3'd5, 7'h20, 5'd7, 32'h8000_0000, 32'd0, 32'd4, 32'd0);
    tick();
    chk("srai_op", 32'(operation), 32'(ALU_SRA));
    chk("srai_b", operand_b, 32'd4);
    funct7 = 7'h01;
    tick();
    in_valid = 1'b0;
    chk("srai_bad_ill", 32'(illegal), 32'd1);
    chk("srai_bad_rw", 32'(reg_write), 32'd0);
    tick();

    // LUI / AUIPC / BLTU
    set_instr(OPC_LUI, 3'd0, 7'd0, 5'd1, 32'h55, 32'h66, 32'h1234_5000, 32'd0);
    tick();
    chk("lui_a", operand_a, 32'd0);
    chk("lui_b", operand_b, 32'h1234_5000);
    chk("lui_op", 32'(operation), 32'(ALU_ADD));
    set_instr(OPC_AUIPC, 3'd0, 7'd0, 5'd2, 32'h55, 32'h66, 32'h10, 32'h100);
    tick();
    chk("auipc_a", operand_a, 32'h100);
    set_instr(OPC_BRANCH, 3'd6, 7'd0, 5'd3, 32'd1, 32'd2, 32'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("bltu_op", 32'(operation), 32'(ALU_BLTU));
    chk("bltu_br", 32'(is_branch), 32'd1);
    chk("bltu_rw", 32'(reg_write), 32'd0);
    tick();

    // Backpressure: three back-to-back, the third waits for space
    out_ready = 1'b0; c0 = consumed;
    set_instr(OPC_OP, 3'd0, 7'd0, 5'd1, 32'd1, 32'd0, 32'd0, 32'd0); tick();
    set_instr(OPC_OP, 3'd0, 7'd0, 5'd2, 32'd2, 32'd0, 32'd0, 32'd0); tick();
    set_instr(OPC_OP, 3'd0, 7'd0, 5'd3, 32'd3, 32'd0, 32'd0, 32'd0);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    chk("bp_hold_first", operand_a, 32'd1);
    out_ready = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("bp_consumed", 32'(consumed - c0), 32'd3);

    // Flush with both entries full and a concurrent input
    out_ready = 1'b0;
    set_instr(OPC_OP, 3'd4, 7'd0, 5'd8, 32'hA, 32'hB, 32'd0, 32'd0); tick();
    set_instr(OPC_OP, 3'd6, 7'd0, 5'd9, 32'hC, 32'hD, 32'd0, 32'd0); tick();
    set_instr(OPC_OP, 3'd7, 7'd0, 5'd10, 32'hE, 32'hF, 32'd0, 32'd0);
    flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1; c0 = consumed;
    repeat (3) tick();
    chk("flush_nothing_out", 32'(consumed - c0), 32'd0);

    // Reset while stalled with both entries full
    out_ready = 1'b0;
    set_instr(OPC_LOAD, 3'd2, 7'd0, 5'd4, 32'h40, 32'd0, 32'h8, 32'd0); tick();
    set_instr(OPC_STORE, 3'd2, 7'd0, 5'd4, 32'h44, 32'h1, 32'hC, 32'd0); tick();
    reset = 1'b1; tick();
    reset = 1'b0; in_valid = 1'b0;
    check_reset_state();
    tick();

    // Random traffic
    repeat (400) begin
      set_instr(($urandom_range(0, 5) == 0) ? 7'($urandom) : opc_list[$urandom_range(0, 7)],
                3'($urandom),
                ($urandom_range(0, 3) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00),
                5'($urandom), $urandom, $urandom, $urandom, $urandom);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
